decode_sb: RTL and testbench

Parametrised successor to the Beta decode stage. Holds one instruction slot with valid/ready handshakes on both sides and an internal register file with write-through. It replaces bypass-mux hazard detection with a per-register pending-write scoreboard, so it supports arbitrary downstream latency. It sits between fetch and execute.

---
 rtl/decode_sb.sv | 159 +++++++++++++++
 tb/tb_decode_sb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sb.sv
// Decode stage with one instruction slot, a write-through register file and
// a per-register pending-write scoreboard that stalls the slot on RAW hazards.
module decode_sb #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     ir_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] a_out,
    output logic [XLEN-1:0] b_out,
    output logic [XLEN-1:0] d_out,
    output logic [XLEN-1:0] br_addr,
    output logic [XLEN-1:0] j_addr,
    output logic            zr,
    output logic            op_ld,
    output logic            op_st,
    output logic            op_ldr,
    output logic            op_jmp,
    output logic            op_beq,
    output logic            op_bne,
    output logic            op_illegal,
    output logic            dest_we,
    input  logic            wb_valid,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    localparam int AW = $clog2(NREG);
    localparam logic [31:0] NOP = {6'h20, 5'd31, 5'd31, 5'd31, 11'd0};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  slot_valid;
    logic [31:0]           slot_ir;
    logic [XLEN-1:0]       slot_pc;
    logic [XLEN-1:0]       regs [NREG];
    logic [CNT_W-1:0]      cnt  [NREG];

    logic [5:0]            opcode;
    logic [4:0]            rc, ra, rb;
    logic [15:0]           c;
    logic                  is_alu, alu_reg, alu_const;
    logic                  use_ra, use_rb, use_rc, writes_rc;
    logic                  wb_dec, wb_commit, hazard, issue;
    logic [XLEN-1:0]       ra_val, rb_val, rc_val, sxt_c;
    logic [CNT_W-1:0]      wb_cnt;
    logic [NREG-1:0]       inc_vec, dec_vec;

    function automatic logic is_zero(input logic [4:0] idx);
        return {27'd0, idx} >= 32'(NREG - 1);
    endfunction

    // A source is busy while writers remain in flight, unless the last one retires this cycle.
    function automatic logic busy(input logic [4:0] idx, input logic [CNT_W-1:0] n, input logic hit);
        return !is_zero(idx) && n != '0 && !(hit && n == CNT_W'(1));
    endfunction

    assign ir_out = slot_valid ? slot_ir : NOP;
    assign pc_out = slot_pc;
    assign opcode = ir_out[31:26];
    assign rc     = ir_out[25:21];
    assign ra     = ir_out[20:16];
    assign rb     = ir_out[15:11];
    assign c      = ir_out[15:0];

    assign op_ld      = opcode == 6'h18;
    assign op_st      = opcode == 6'h19;
    assign op_jmp     = opcode == 6'h1B;
    assign op_beq     = opcode == 6'h1C;
    assign op_bne     = opcode == 6'h1D;
    assign op_ldr     = opcode == 6'h1F;
    assign is_alu     = opcode[5];
    assign alu_reg    = opcode[5:4] == 2'b10;
    assign alu_const  = opcode[5:4] == 2'b11;
    assign op_illegal = !(op_ld || op_st || op_jmp || op_beq || op_bne || op_ldr || is_alu);

    assign use_ra    = is_alu || op_ld || op_st || op_jmp || op_beq || op_bne;
    assign use_rb    = alu_reg;
    assign use_rc    = op_st;
    assign writes_rc = is_alu || op_ld || op_ldr || op_jmp || op_beq || op_bne;
    assign dest_we   = writes_rc && !is_zero(rc);

    assign wb_dec    = wb_valid && !is_zero(wb_addr);
    assign wb_commit = wb_dec && wb_we;
    assign wb_cnt    = cnt[wb_addr[AW-1:0]];

    assign ra_val = is_zero(ra) ? '0 : (wb_commit && wb_addr == ra) ? wb_data : regs[ra[AW-1:0]];
    assign rb_val = is_zero(rb) ? '0 : (wb_commit && wb_addr == rb) ? wb_data : regs[rb[AW-1:0]];
    assign rc_val = is_zero(rc) ? '0 : (wb_commit && wb_addr == rc) ? wb_data : regs[rc[AW-1:0]];

    assign hazard = (use_ra && busy(ra, cnt[ra[AW-1:0]], wb_dec && wb_addr == ra))
                 || (use_rb && busy(rb, cnt[rb[AW-1:0]], wb_dec && wb_addr == rb))
                 || (use_rc && busy(rc, cnt[rc[AW-1:0]], wb_dec && wb_addr == rc))
                 || (dest_we && cnt[rc[AW-1:0]] == CNT_MAX);

    assign out_valid = slot_valid && !hazard && !flush;
    assign issue     = out_valid && out_ready;
    assign in_ready  = !slot_valid || issue;

    assign sxt_c   = {{(XLEN-16){c[15]}}, c};
    assign br_addr = pc_out + {sxt_c[XLEN-3:0], 2'b00};
    assign a_out   = op_ldr ? br_addr : ra_val;
    assign b_out   = (op_ld || op_st || alu_const) ? sxt_c : rb_val;
    assign d_out   = rc_val;
    assign j_addr  = ra_val;
    assign zr      = ra_val == '0;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = issue && dest_we && rc == 5'(i);
            dec_vec[i] = wb_dec && wb_addr == 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_ir    <= NOP;
            slot_pc    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (flush)
                slot_valid <= 1'b0;
            else if (in_valid && in_ready) begin
                slot_valid <= 1'b1;
                slot_ir    <= in_ir;
                slot_pc    <= in_pc;
            end else if (issue)
                slot_valid <= 1'b0;

            for (int i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
                if (wb_commit && wb_addr == 5'(i))
                    regs[i] <= wb_data;
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(wb_dec && wb_cnt == '0));

endmodule

// File: tb/tb_decode_sb.sv
// Bench for decode_sb: directed hazard scenarios followed by random traffic,
// all checked cycle by cycle against a register/scoreboard reference model.
module tb_decode_sb;

    localparam logic [31:0] NOP_WORD = 32'h83FF_F800;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_ir, in_pc, ir_out, pc_out, a_out, b_out, d_out, br_addr, j_addr;
    logic        zr, op_ld, op_st, op_ldr, op_jmp, op_beq, op_bne, op_illegal, dest_we;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int nvec = 0;
    int nfail = 0;

    // Reference model state: architectural values, in-flight writer counts, slot.
    logic [31:0] mreg [32];
    int          mcnt [32];
    bit          mvalid;
    logic [31:0] mir, mpc;
    int          pend [$];

    bit          exp_ov, exp_ir_rdy, exp_dest, exp_zr;
    logic [4:0]  exp_rc;
    logic [6:0]  exp_flags;
    logic [31:0] exp_ir, exp_a, exp_b, exp_d, exp_br, exp_j;

    decode_sb #(.XLEN(32), .NREG(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ir_out(ir_out), .pc_out(pc_out), .a_out(a_out), .b_out(b_out), .d_out(d_out),
        .br_addr(br_addr), .j_addr(j_addr), .zr(zr), .op_ld(op_ld), .op_st(op_st),
        .op_ldr(op_ldr), .op_jmp(op_jmp), .op_beq(op_beq), .op_bne(op_bne),
        .op_illegal(op_illegal), .dest_we(dest_we), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rcx,
                                        input logic [4:0] rax, input logic [15:0] cx);
        return {op, rcx, rax, cx};
    endfunction

    function automatic logic [31:0] mval(input logic [4:0] r);
        if (r == 5'd31) return 32'd0;
        if (wb_valid && wb_we && wb_addr == r) return wb_data;
        return mreg[r];
    endfunction

    function automatic bit mpending(input logic [4:0] r);
        if (r == 5'd31) return 1'b0;
        return (mcnt[r] - ((wb_valid && wb_addr == r) ? 1 : 0)) > 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [31:0] ir, input logic [31:0] pc,
                                 input bit ordy, input bit fl, input bit wv, input bit wwe,
                                 input logic [4:0] wa, input logic [31:0] wd);
        in_valid  = iv;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        wb_valid  = wv;
        wb_we     = wwe;
        wb_addr   = wa;
        wb_data   = wd;
    endtask

    task automatic retire(input logic [4:0] r);
        for (int k = 0; k < pend.size(); k++)
            if (pend[k] == int'(r)) begin
                pend.delete(k);
                break;
            end
    endtask

    // Expected outputs come straight from the instruction-class rules.
    task automatic predict();
        logic [5:0]  op;
        logic [4:0]  ra, rb;
        logic [15:0] c;
        logic [31:0] sx;
        bit sa, sb, sc, wr, bconst, legal, hz;
        exp_ir = mvalid ? mir : enc(6'h20, 5'd31, 5'd31, 16'hF800);
        op = exp_ir[31:26];
        exp_rc = exp_ir[25:21];
        ra = exp_ir[20:16];
        rb = exp_ir[15:11];
        c  = exp_ir[15:0];
        sa = 0; sb = 0; sc = 0; wr = 0; bconst = 0; legal = 1;
        if (op >= 6'h20) begin
            sa = 1; wr = 1;
            if (op < 6'h30) sb = 1; else bconst = 1;
        end else begin
            case (op)
                6'h18:                      begin sa = 1; wr = 1; bconst = 1; end
                6'h19:                      begin sa = 1; sc = 1; bconst = 1; end
                6'h1B, 6'h1C, 6'h1D:        begin sa = 1; wr = 1; end
                6'h1F:                      wr = 1;
                default:                    legal = 0;
            endcase
        end
        exp_dest = wr && exp_rc != 5'd31;
        hz = (sa && mpending(ra)) || (sb && mpending(rb)) || (sc && mpending(exp_rc))
          || (exp_dest && mcnt[exp_rc] >= 3);
        exp_ov     = mvalid && !hz && !flush;
        exp_ir_rdy = !mvalid || (exp_ov && out_ready);
        sx         = 32'($signed(c));
        exp_br     = mpc + sx * 4;
        exp_a      = (op == 6'h1F) ? exp_br : mval(ra);
        exp_b      = bconst ? sx : mval(rb);
        exp_d      = mval(exp_rc);
        exp_j      = mval(ra);
        exp_zr     = mval(ra) == 32'd0;
        exp_flags  = {op == 6'h18, op == 6'h19, op == 6'h1F, op == 6'h1B,
                      op == 6'h1C, op == 6'h1D, !legal};
    endtask

    task automatic evalCycle();
        @(negedge clk);
        predict();
        if (!rst) begin
            checkOutput("out_valid", out_valid, exp_ov);
            checkOutput("in_ready", in_ready, exp_ir_rdy);
            checkOutput("ir_out", ir_out, exp_ir);
            checkOutput("op_flags", {op_ld, op_st, op_ldr, op_jmp, op_beq, op_bne, op_illegal}, exp_flags);
            checkOutput("dest_we", dest_we, exp_dest);
            if (mvalid) begin
                checkOutput("pc_out", pc_out, mpc);
                checkOutput("a_out", a_out, exp_a);
                checkOutput("b_out", b_out, exp_b);
                checkOutput("d_out", d_out, exp_d);
                checkOutput("br_addr", br_addr, exp_br);
                checkOutput("j_addr", j_addr, exp_j);
                checkOutput("zr", zr, exp_zr);
            end
        end
    endtask

    task automatic endCycle();
        bit issue;
        @(posedge clk);
        if (rst) begin
            mvalid = 0;
            for (int r = 0; r < 32; r++) begin
                mcnt[r] = 0;
                mreg[r] = 32'd0;
            end
            pend.delete();
        end else begin
            issue = exp_ov && out_ready;
            if (issue && exp_dest) begin
                mcnt[exp_rc]++;
                pend.push_back(int'(exp_rc));
            end
            if (wb_valid && wb_addr != 5'd31 && mcnt[wb_addr] > 0) mcnt[wb_addr]--;
            if (wb_valid && wb_we && wb_addr != 5'd31) mreg[wb_addr] = wb_data;
            if (flush) mvalid = 0;
            else if (in_valid && exp_ir_rdy) begin
                mvalid = 1;
                mir = in_ir;
                mpc = in_pc;
            end else if (issue) mvalid = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
            evalCycle();
            endCycle();
        end
    endtask

    task automatic drain();
        logic [4:0] r;
        while (pend.size() > 0) begin
            r = 5'(pend.pop_front());
            applyStimulus(0, 32'd0, 32'd0, 1, 0, 1, 1, r, $urandom);
            evalCycle();
            endCycle();
        end
        idle(2);
    endtask

    initial begin
        logic [5:0]  ops  [15] = '{6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F, 6'h20, 6'h22,
                                   6'h30, 6'h33, 6'h3F, 6'h00, 6'h05, 6'h1A, 6'h1E};
        logic [4:0]  regp [7]  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd31};
        logic [31:0] w;
        logic [4:0]  wa;
        bit          wv;

        rst = 1;
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle(); endCycle();
        evalCycle(); endCycle();
        rst = 0;
        evalCycle();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_ir_nop", ir_out, NOP_WORD);
        endCycle();

        // ADDC R1,R31,5 then ADD R2,R1,R1 waiting on R1's writeback.
        applyStimulus(1, enc(6'h30, 5'd1, 5'd31, 16'd5), 32'h10, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle(); endCycle();
        applyStimulus(1, enc(6'h20, 5'd2, 5'd1, {5'd1, 11'd0}), 32'h14, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle(); endCycle();
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t1_stall", out_valid, 0);
        endCycle();
        retire(5'd1);
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 1, 1, 5'd1, 32'd5);
        evalCycle();
        checkOutput("t1_release", out_valid, 1);
        checkOutput("t1_a_fwd", a_out, 32'd5);
        checkOutput("t1_b_fwd", b_out, 32'd5);
        endCycle();

        // LDR R3 with PC+4 = 0x104 and C = 4.
        retire(5'd2);
        applyStimulus(1, enc(6'h1F, 5'd3, 5'd0, 16'h0004), 32'h104, 1, 0, 1, 1, 5'd2, 32'hA);
        evalCycle(); endCycle();
        applyStimulus(1, enc(6'h19, 5'd31, 5'd6, 16'd8), 32'h108, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t2_ldr_a", a_out, 32'h114);
        checkOutput("t2_ldr_go", out_valid, 1);
        endCycle();
        applyStimulus(1, enc(6'h00, 5'd7, 5'd1, 16'd0), 32'h10C, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t6_st_r31_go", out_valid, 1);
        checkOutput("t6_st_r31_d", d_out, 32'd0);
        endCycle();
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t6_illegal", op_illegal, 1);
        checkOutput("t6_ill_dest", dest_we, 0);
        endCycle();
        drain();

        // Four writers to R4: the fourth waits for a retirement.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, enc(6'h30, 5'd4, 5'd31, 16'(k + 1)), 32'h200, 1, 0, 0, 0, 5'd0, 32'd0);
            evalCycle(); endCycle();
        end
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t3_sat_stall", out_valid, 0);
        endCycle();
        retire(5'd4);
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 1, 1, 5'd4, 32'h44);
        evalCycle(); endCycle();
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t3_sat_go", out_valid, 1);
        endCycle();
        drain();

        // Back-pressure: slot held for five cycles.
        applyStimulus(1, enc(6'h30, 5'd0, 5'd31, 16'd7), 32'h300, 0, 0, 0, 0, 5'd0, 32'd0);
        evalCycle(); endCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, enc(6'h20, 5'd1, 5'd2, 16'h1800), 32'h304, 0, 0, 0, 0, 5'd0, 32'd0);
            evalCycle();
            checkOutput("t4_hold_ready", in_ready, 0);
            endCycle();
        end
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t4_release", out_valid, 1);
        endCycle();

        // Flush with the slot full and a new instruction arriving.
        applyStimulus(1, enc(6'h30, 5'd2, 5'd31, 16'd9), 32'h400, 0, 0, 0, 0, 5'd0, 32'd0);
        evalCycle(); endCycle();
        applyStimulus(1, enc(6'h30, 5'd3, 5'd31, 16'd1), 32'h404, 1, 1, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t5_flush_ov", out_valid, 0);
        endCycle();
        applyStimulus(0, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        evalCycle();
        checkOutput("t5_empty", out_valid, 0);
        checkOutput("t5_nop", ir_out, NOP_WORD);
        endCycle();
        drain();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            w = enc(ops[$urandom_range(0, 14)], regp[$urandom_range(0, 6)],
                    regp[$urandom_range(0, 6)],
                    {regp[$urandom_range(0, 6)], 11'($urandom)});
            wv = 0;
            wa = 5'($urandom);
            if (pend.size() > 0 && $urandom_range(0, 99) < 40) begin
                int k;
                k = $urandom_range(0, pend.size() - 1);
                wa = 5'(pend[k]);
                pend.delete(k);
                wv = 1;
            end
            applyStimulus($urandom_range(0, 99) < 70, w, {$urandom, 2'b00} >> 2 << 2,
                          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                          wv, $urandom_range(0, 99) < 80, wa, $urandom);
            evalCycle();
            endCycle();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
